// File: rtl/decim_avg.sv
// decim_avg: accumulate-and-dump boxcar decimator.
// Sums 2^LOG2_DEC accepted signed samples and emits the floored mean through a
// one-entry valid/ready output register. The input side is never stalled; a
// result that finds the output register still occupied is discarded and
// recorded in the sticky io_dropped flag.
module decim_avg #(
    parameter int DATA_W   = 32,
    parameter int LOG2_DEC = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    input  logic [DATA_W-1:0] io_in_value,
    input  logic              io_out_ready,
    output logic              io_out_valid,
    output logic [DATA_W-1:0] io_out_value,
    output logic              io_dropped
);

    localparam int ACC_W = DATA_W + LOG2_DEC;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } outState_e;

    outState_e           state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_DEC-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]   value_q, value_d;
    logic                dropped_q, dropped_d;

    logic [ACC_W-1:0]    sum;
    logic [DATA_W-1:0]   res;
    logic                dump;
    logic                transfer;

    // The accumulator carries LOG2_DEC guard bits, so the sum never wraps and
    // dropping its low LOG2_DEC bits is an arithmetic shift that floors
    // toward -inf while always fitting back into DATA_W bits.
    assign sum      = acc_q + {{LOG2_DEC{io_in_value[DATA_W-1]}}, io_in_value};
    assign res      = sum[ACC_W-1:LOG2_DEC];
    assign dump     = io_in_valid && (cnt_q == {LOG2_DEC{1'b1}});
    assign transfer = (state_q == FULL) && io_out_ready;

    // Accumulate path: only accepted samples advance the window.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (io_in_valid) begin
            if (dump) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + LOG2_DEC'(1);
            end
        end
    end

    // Output register next state: a dump always leaves it FULL, a transfer
    // without a dump empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (dump) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (!dump && transfer) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Output register data: load a result only when there is room for it,
    // otherwise discard it and raise the sticky drop flag.
    always_comb begin
        value_d   = value_q;
        dropped_d = dropped_q;
        if (dump) begin
            if ((state_q == EMPTY) || transfer) begin
                value_d = res;
            end else begin
                dropped_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset overriding all events.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= EMPTY;
            acc_q     <= '0;
            cnt_q     <= '0;
            value_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            dropped_q <= dropped_d;
        end
    end

    assign io_out_valid = (state_q == FULL);
    assign io_out_value = value_q;
    assign io_dropped   = dropped_q;

endmodule

// File: tb/tb_decim_avg.sv
// tb_decim_avg: self-checking bench for decim_avg (DATA_W = 32, LOG2_DEC = 3).
// A behavioural model of the window and the output register predicts every
// result into a scoreboard queue as stimulus is driven; outputs are compared
// every cycle, plus table-driven windows with hand-computed means and
// directed back-pressure and mid-window reset sequences.
module tb_decim_avg;

    logic        clock;
    logic        reset;
    logic        io_in_valid;
    logic [31:0] io_in_value;
    logic        io_out_ready;
    logic        io_out_valid;
    logic [31:0] io_out_value;
    logic        io_dropped;

    int nCompared;
    int nMismatched;
    int dutXfers;

    longint      mAcc;
    int          mCnt;
    logic        mFull;
    logic        mDropped;
    logic [31:0] expQ[$];

    typedef struct {
        logic [31:0] samples [8];
        logic [31:0] expected;
    } winVec_t;

    winVec_t tbl [7];

    decim_avg #(
        .DATA_W  (32),
        .LOG2_DEC(3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_in_valid (io_in_valid),
        .io_in_value (io_in_value),
        .io_out_ready(io_out_ready),
        .io_out_valid(io_out_valid),
        .io_out_value(io_out_value),
        .io_dropped  (io_dropped)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Floor division by 8 written independently of any bit shifting.
    function automatic longint floorDiv8(input longint s);
        longint q;
        q = s / 8;
        if ((s % 8 != 0) && (s < 0)) begin
            q = q - 1;
        end
        return q;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, then check all outputs.
    task automatic applyStimulus(input logic rstn, input logic vld,
                                 input logic [31:0] val, input logic rdy);
        logic   xferM;
        logic   dumpM;
        longint s;
        reset        = rstn;
        io_in_valid  = vld;
        io_in_value  = val;
        io_out_ready = rdy;
        if (rstn && io_out_valid && rdy) begin
            dutXfers++;
        end
        if (!rstn) begin
            mAcc     = 0;
            mCnt     = 0;
            mFull    = 1'b0;
            mDropped = 1'b0;
            expQ.delete();
        end else begin
            xferM = mFull && rdy;
            dumpM = vld && (mCnt == 7);
            if (xferM) begin
                void'(expQ.pop_front());
                mFull = 1'b0;
            end
            if (vld) begin
                s = mAcc + longint'($signed(val));
                if (dumpM) begin
                    if (!mFull) begin
                        expQ.push_back(32'(floorDiv8(s)));
                        mFull = 1'b1;
                    end else begin
                        mDropped = 1'b1;
                    end
                    mAcc = 0;
                    mCnt = 0;
                end else begin
                    mAcc = s;
                    mCnt = mCnt + 1;
                end
            end
        end
        @(posedge clock);
        #1;
        checkOutput("out_valid", {31'b0, io_out_valid}, {31'b0, mFull});
        checkOutput("dropped", {31'b0, io_dropped}, {31'b0, mDropped});
        if (!rstn) begin
            checkOutput("reset_value", io_out_value, 32'h0);
        end else if (mFull && (expQ.size() > 0)) begin
            checkOutput("out_value", io_out_value, expQ[0]);
        end
    endtask

    // Main sequence: reset, table windows, then directed corner cases.
    initial begin
        int remaining;
        int xfersBefore;
        logic v;
        nCompared   = 0;
        nMismatched = 0;
        dutXfers    = 0;
        mAcc        = 0;
        mCnt        = 0;
        mFull       = 1'b0;
        mDropped    = 1'b0;
        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_in_value  = 32'h0;
        io_out_ready = 1'b0;

        tbl[0].samples = '{32'd1048576, 32'd1048576, 32'd1048576, 32'd1048576,
                           32'd1048576, 32'd1048576, 32'd1048576, 32'd1048576};
        tbl[0].expected = 32'd1048576;
        tbl[1].samples = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0,
                           32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1].expected = 32'hFFFFFFFF;
        tbl[2].samples = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD,
                           32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD};
        tbl[2].expected = 32'hFFFFFFFD;
        tbl[3].samples = '{32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[3].expected = 32'd0;
        tbl[4].samples = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                           32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
        tbl[4].expected = 32'h7FFFFFFF;
        tbl[5].samples = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                           32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
        tbl[5].expected = 32'h80000000;
        tbl[6].samples = '{32'hFFFFFF9C, 32'd0, 32'd0, 32'd0,
                           32'd0, 32'd0, 32'd0, 32'd0};
        tbl[6].expected = 32'hFFFFFFF3;

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h12345678, 1'b1);

        // Table windows back to back with the consumer always ready.
        for (int w = 0; w < 7; w++) begin
            for (int j = 0; j < 8; j++) begin
                applyStimulus(1'b1, 1'b1, tbl[w].samples[j], 1'b1);
            end
            checkOutput("tbl_valid", {31'b0, io_out_valid}, 32'd1);
            checkOutput("tbl_value", io_out_value, tbl[w].expected);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

        // Eight valid samples scattered over 20 cycles with garbage in gaps.
        xfersBefore = dutXfers;
        remaining   = 8;
        for (int c = 0; c < 20; c++) begin
            if (remaining == 20 - c) begin
                v = 1'b1;
            end else if (remaining > 0) begin
                v = 1'($urandom_range(0, 1));
            end else begin
                v = 1'b0;
            end
            if (v) begin
                remaining--;
            end
            applyStimulus(1'b1, v, $urandom, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("gap_one_result", 32'(dutXfers - xfersBefore), 32'd1);

        // No bubble: transfer coincides with the next dump, drop flag stays 0.
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b1, 1'b1, 32'd800, 1'b0);
        end
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b1, 1'b1, 32'd1600, (j == 7));
        end
        checkOutput("nobubble_valid", {31'b0, io_out_valid}, 32'd1);
        checkOutput("nobubble_value", io_out_value, 32'd1600);
        checkOutput("nobubble_dropped", {31'b0, io_dropped}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

        // Back-pressure across two windows: A held, B discarded.
        for (int j = 0; j < 16; j++) begin
            applyStimulus(1'b1, 1'b1, (j < 8) ? 32'd4000 : 32'd9000, 1'b0);
        end
        checkOutput("bp_value_held", io_out_value, 32'd4000);
        checkOutput("bp_dropped", {31'b0, io_dropped}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("bp_drained", {31'b0, io_out_valid}, 32'd0);

        // Reset mid-window: partial sum must not leak into the next result.
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b1, 1'b1, 32'd1048576, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 32'd1048576, 1'b1);
        checkOutput("rst_dropped", {31'b0, io_dropped}, 32'd0);
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b1, 1'b1, 32'd2097152, 1'b1);
            if (j < 7) begin
                checkOutput("rst_no_early", {31'b0, io_out_valid}, 32'd0);
            end
        end
        checkOutput("rst_first_value", io_out_value, 32'd2097152);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/decim_avg.md
Name: decim_avg

Overview:
- Streaming accumulate-and-dump decimator that sits directly downstream of the IIR filter stage.
- Consumes the filter's signed 32-bit fixed-point samples (Q11.20, 1.0 = 2^20) and emits one boxcar-averaged sample per 2^LOG2_DEC accepted inputs.
- The output is held in a one-entry valid/ready register, so a slower consumer (logger, UART packer) can back-pressure.
- The input is never stalled; the filter runs free.

Parameters:
- DATA_W, 32, sample width in bits, signed two's complement.
- LOG2_DEC, 3, log2 of the decimation ratio N (N = 8 by default); legal range 1..8.

Ports:
- clock  input  1  single clock for all state, rising edge.
- reset  input  1  synchronous, active-low reset; 0 sampled on a rising edge clears all state.
- io_in_valid  input  1  io_in_value carries a sample this cycle.
- io_in_value  input  DATA_W  signed input sample.
- io_out_ready  input  1  consumer accepts io_out_value this cycle.
- io_out_valid  output  1  io_out_value holds an unconsumed result.
- io_out_value  output  DATA_W  signed averaged sample.
- io_dropped  output  1  sticky flag: at least one result was discarded because of back-pressure.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - acc = 0, cnt = 0.
  - io_out_valid = 0, io_out_value = 0, io_dropped = 0.
  - Reset overrides every other event in the same cycle.
- Accumulator and counter:
  - acc is signed, DATA_W + LOG2_DEC bits wide; it cannot overflow.
  - cnt counts 0..N-1.
  - Only cycles with io_in_valid = 1 count. Cycles with io_in_valid = 0 change nothing in the accumulate path.
- Accepted sample with cnt < N-1: acc <= acc + sext(in), cnt <= cnt + 1.
- Accepted sample with cnt == N-1 (dump):
  - res = (acc + sext(in)) >>> LOG2_DEC, an arithmetic shift that floors toward -inf.
  - res always fits in DATA_W, so no saturation is needed.
  - acc <= 0, cnt <= 0.
- Output register, two states:
  - EMPTY (io_out_valid = 0).
  - FULL (io_out_valid = 1).
- Transfer: a result is consumed on any edge where io_out_valid and io_out_ready are both 1.
- Latency: res appears on io_out_value, with io_out_valid = 1, on the first edge after the dump cycle. That is 1 cycle after the Nth sample is presented.
- Transitions:
  - EMPTY, dump: load res, go to FULL.
  - EMPTY, no dump: stay EMPTY.
  - FULL, transfer and dump in the same cycle: load res, stay FULL (back-to-back results, no bubble).
  - FULL, transfer without dump: go to EMPTY; io_out_value keeps its last value (don't-care).
  - FULL, dump without transfer: keep the old value, discard res, set io_dropped = 1.
  - FULL, neither: hold io_out_value and io_out_valid stable.
- io_dropped: cleared only by reset.
- Windowing: averaging windows are aligned to the first accepted sample after reset. Windows never overlap and never restart except on reset.
- Reset mid-window: the partial sum is discarded, and the next output requires N fresh accepted samples.
- io_out_ready is ignored while io_out_valid = 0.
- No combinational path from io_out_ready to any output.

Test Plan:
- Constant input: LOG2_DEC = 3, io_in_value = 1048576 (1.0), io_in_valid = 1 every cycle, io_out_ready = 1.
  -> First io_out_valid 1 cycle after the 8th sample, value 1048576.
  -> Then one result every 8 cycles, io_dropped = 0.
- Floor rounding: one window of -1 followed by seven 0s -> output -1 (0xFFFFFFFF). A window of eight -3s -> -3. A window summing to +7 -> 0.
- Extremes: eight samples of 0x7FFFFFFF -> 0x7FFFFFFF. Eight samples of 0x80000000 -> 0x80000000. No wrap in either case.
- Valid gaps: 8 samples spread over 20 cycles with io_in_valid toggling pseudo-randomly.
  -> Exactly one result, equal to floor(sum/8).
  -> It appears 1 cycle after the 8th valid sample.
- Back-pressure: io_out_ready = 0 across two full windows (result A, then B).
  -> A is held stable, B is discarded, io_dropped = 1.
  -> Raising io_out_ready delivers A, then io_out_valid = 0.
  -> A transfer in the same cycle as a dump (no bubble) keeps io_out_valid high and io_dropped unchanged.
- Reset mid-window: 5 samples of 1048576, then reset = 0 for 1 cycle, then constant 2097152.
  -> All outputs are 0 after reset.
  -> The first result is 2097152, produced after 8 post-reset samples.
  -> The partial 5-sample sum never leaks.
